hdmi_wr_sched: RTL

Write-side scheduler between the decimated HDMI capture stream (vs/de/RGB565) and the shared DDR write arbiter. It packs pixels into 128-bit words and buffers them in a small FIFO. It issues fixed-length burst requests with frame-buffer addresses and ping-pongs between two frame banks. It publishes the last complete bank to the display reader.

---
 rtl/hdmi_wr_sched_pkg.sv | 26 ++
 rtl/hdmi_wr_sched_if.sv | 33 +++
 rtl/hdmi_wr_sched_sync_fifo.sv | 60 ++++++
 rtl/hdmi_wr_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_wr_sched_pkg.sv
// Shared types, widths and address helper for the HDMI write-side scheduler.
package hdmi_wr_sched_pkg;

  localparam int unsigned AddrW      = 28;
  localparam int unsigned DataW      = 128;
  localparam int unsigned PixW       = 16;
  localparam int unsigned PixPerWord = DataW / PixW;
  localparam int unsigned WordBytes  = DataW / 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StData = 2'd2
  } wr_state_e;

  // Byte address of a 128-bit word within the selected frame bank.
  function automatic logic [AddrW-1:0] burst_addr(input logic [AddrW-1:0] base,
                                                  input logic [AddrW-1:0] stride,
                                                  input logic             bank,
                                                  input logic [AddrW-1:0] word_idx);
    logic [AddrW-1:0] bank_off;
    bank_off = bank ? stride : '0;
    return base + bank_off + (word_idx * AddrW'(WordBytes));
  endfunction

endpackage

// File: rtl/hdmi_wr_sched_if.sv
// Burst write handshake between the scheduler (master) and the DDR write arbiter (slave).
interface hdmi_wr_sched_if;
  import hdmi_wr_sched_pkg::*;

  logic             wr_req;
  logic             wr_grant;
  logic [AddrW-1:0] wr_addr;
  logic [7:0]       wr_len;
  logic [DataW-1:0] wr_data;
  logic             wr_data_valid;
  logic             wr_data_ready;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_len,
    output wr_data,
    output wr_data_valid,
    input  wr_grant,
    input  wr_data_ready
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_len,
    input  wr_data,
    input  wr_data_valid,
    output wr_grant,
    output wr_data_ready
  );

endinterface

// File: rtl/hdmi_wr_sched_sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; head is combinational.
module hdmi_wr_sched_sync_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 32,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [CntW-1:0]  count,
  output logic             full
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; flush discards everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hdmi_wr_sched.sv
// HDMI capture write scheduler: packs RGB565 pixels into 128-bit words, bursts them to
// DDR through the write arbiter and ping-pongs between two frame banks.
module hdmi_wr_sched
  import hdmi_wr_sched_pkg::*;
#(
  parameter int unsigned      H_PIX      = 1280,
  parameter int unsigned      V_LINES    = 720,
  parameter int unsigned      BURST_LEN  = 16,
  parameter logic [AddrW-1:0] BASE_ADDR  = 28'h0,
  parameter logic [AddrW-1:0] BANK_BYTES = 28'h0200000
) (
  input  logic             hdmi_pix_clk_in,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             err_clr,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [PixW-1:0]  rgb565_in,
  hdmi_wr_sched_if.master  wr,
  output logic             frame_done,
  output logic             rd_bank,
  output logic             ovf_err,
  output logic             frame_err
);

  localparam int unsigned FrameWords = H_PIX * V_LINES / PixPerWord;
  localparam int unsigned FifoDepth  = 2 * BURST_LEN;
  localparam int unsigned CntW       = $clog2(FifoDepth + 1);
  localparam int unsigned IdxW       = $clog2(FrameWords + 1);
  localparam int unsigned BeatW      = $clog2(BURST_LEN + 1);
  localparam int unsigned LaneW      = $clog2(PixPerWord);

  // Packer state
  logic [LaneW-1:0]      lane_q;
  logic [DataW-PixW-1:0] pix_buf_q;
  logic [DataW-1:0]      word_q;
  logic                  push_q;

  // Control state
  wr_state_e         state_q;
  logic              vs_q;
  logic              pending_sof_q;
  logic              capture_q;
  logic              frame_open_q;
  logic              frame_complete_q;
  logic              bank_q;
  logic [IdxW-1:0]   word_idx_q;
  logic [BeatW-1:0]  beat_q;
  logic              wr_req_q;
  logic [AddrW-1:0]  wr_addr_q;
  logic              valid_q;
  logic              frame_done_q;
  logic              rd_bank_q;
  logic              ovf_q;
  logic              ferr_q;

  // FIFO side
  logic [DataW-1:0]  fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full;

  logic              sof;
  logic              flush;
  logic              beat_ok;
  logic              ovf_set;
  logic [IdxW-1:0]   word_idx_nxt;

  assign sof          = vs_in & ~vs_q;
  assign flush        = (state_q == StIdle) & pending_sof_q;
  assign beat_ok      = valid_q & wr.wr_data_ready;
  assign ovf_set      = push_q & fifo_full;
  assign word_idx_nxt = word_idx_q + 1'b1;

  // Shift pixels in from the top so the first pixel of a word ends up in [15:0].
  always_ff @(posedge hdmi_pix_clk_in or negedge rst) begin
    if (!rst) begin
      lane_q    <= '0;
      pix_buf_q <= '0;
      word_q    <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (sof) begin
        lane_q <= '0;
      end else if (capture_q && de_in) begin
        if (lane_q == LaneW'(PixPerWord - 1)) begin
          word_q <= {rgb565_in, pix_buf_q};
          push_q <= 1'b1;
          lane_q <= '0;
        end else begin
          pix_buf_q <= {rgb565_in, pix_buf_q[DataW-PixW-1:PixW]};
          lane_q    <= lane_q + 1'b1;
        end
      end
    end
  end

  // Burst FSM with SOF resolution, bank ping-pong and sticky error flags.
  always_ff @(posedge hdmi_pix_clk_in or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      vs_q             <= 1'b0;
      pending_sof_q    <= 1'b0;
      capture_q        <= 1'b0;
      frame_open_q     <= 1'b0;
      frame_complete_q <= 1'b0;
      bank_q           <= 1'b0;
      word_idx_q       <= '0;
      beat_q           <= '0;
      wr_req_q         <= 1'b0;
      wr_addr_q        <= '0;
      valid_q          <= 1'b0;
      frame_done_q     <= 1'b0;
      rd_bank_q        <= 1'b0;
      ovf_q            <= 1'b0;
      ferr_q           <= 1'b0;
    end else begin
      vs_q         <= vs_in;
      frame_done_q <= 1'b0;

      if (err_clr) begin
        ovf_q  <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pending_sof_q) begin
            word_idx_q <= '0;
            // Only a frame that was actually being captured can be short.
            if (frame_complete_q) begin
              bank_q <= ~bank_q;
            end else if (frame_open_q && (word_idx_q < IdxW'(FrameWords))) begin
              ferr_q <= 1'b1;
            end
            capture_q        <= cfg_en;
            frame_open_q     <= cfg_en;
            frame_complete_q <= 1'b0;
            pending_sof_q    <= 1'b0;
          end else if (capture_q && (fifo_count >= CntW'(BURST_LEN))) begin
            state_q   <= StReq;
            wr_req_q  <= 1'b1;
            wr_addr_q <= burst_addr(BASE_ADDR, BANK_BYTES, bank_q, AddrW'(word_idx_q));
          end
        end
        StReq: begin
          if (wr.wr_grant) begin
            wr_req_q <= 1'b0;
            valid_q  <= 1'b1;
            beat_q   <= '0;
            state_q  <= StData;
          end
        end
        StData: begin
          if (beat_ok) begin
            beat_q     <= beat_q + 1'b1;
            word_idx_q <= word_idx_nxt;
            if (word_idx_nxt == IdxW'(FrameWords)) begin
              frame_done_q     <= 1'b1;
              rd_bank_q        <= bank_q;
              capture_q        <= 1'b0;
              frame_complete_q <= 1'b1;
            end
            if (beat_q == BeatW'(BURST_LEN - 1)) begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new SOF overrides any capture update made above.
      if (sof) begin
        pending_sof_q <= 1'b1;
        capture_q     <= 1'b0;
      end
    end
  end

  hdmi_wr_sched_sync_fifo #(
    .Width(DataW),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk      (hdmi_pix_clk_in),
    .rst      (rst),
    .flush    (flush),
    .push     (push_q),
    .push_data(word_q),
    .pop      (beat_ok),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  assign wr.wr_req        = wr_req_q;
  assign wr.wr_addr       = wr_addr_q;
  assign wr.wr_len        = 8'(BURST_LEN);
  assign wr.wr_data       = valid_q ? fifo_head : '0;
  assign wr.wr_data_valid = valid_q;

  assign frame_done = frame_done_q;
  assign rd_bank    = rd_bank_q;
  assign ovf_err    = ovf_q;
  assign frame_err  = ferr_q;

endmodule
